sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO: storage array plus pointer, occupancy and flag logic in one block. Successor to the team's bare dual-port FIFO memory: adds read/write handshake, registered read data with valid, fill level, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Used wherever producer and consumer share one clock domain, e.g. datapath skid/rate buffers.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 34 +++
 rtl/sync_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and operation encoding for the single-clock FIFO.
// Pointer and count widths are ADDRSIZE+1 so that a full FIFO (DEPTH words) is representable.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic bit levels_ok(input int af_level, input int ae_level, input int depth);
    return (af_level >= 1) && (af_level <= depth) && (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATASIZE storage with one write port and a registered read port.
// The array itself is never reset; only the read data register is.
module sync_fifo_ram #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic                re_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [DATASIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read data holds its last value whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy counter, status flags and sticky error
// flags around a sync_fifo_ram instance. All flags come from registered state only.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                walmost_full,
  output logic                wovf,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic                rudf,
  output logic [ADDRSIZE:0]   count
);

  localparam int CW    = ptr_width(ADDRSIZE);
  localparam int DEPTH = fifo_depth(ADDRSIZE);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (!levels_ok(AF_LEVEL, AE_LEVEL, DEPTH)) begin : g_bad_levels
    $fatal(1, "sync_fifo_ctrl: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
  end

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wovf_q, wovf_d;
  logic          rudf_q, rudf_d;
  logic          rvalid_q, rvalid_d;
  logic          push, pop;
  fifo_op_e      op;

  assign wfull         = (count_q == DEPTH_C);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AF_C);
  assign ralmost_empty = (count_q <= AE_C);

  // Flush wins over both requests; a full FIFO rejects the push even when a pop frees a slot.
  assign push = winc & ~wfull  & ~clr;
  assign pop  = rinc & ~rempty & ~clr;
  assign op   = fifo_op_e'({pop, push});

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    wovf_d   = wovf_q;
    rudf_d   = rudf_q;
    rvalid_d = pop;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      wovf_d  = 1'b0;
      rudf_d  = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + ONE_C;
      if (pop)  rptr_d = rptr_q + ONE_C;
      unique case (op)
        OP_PUSH: count_d = count_q + ONE_C;
        OP_POP:  count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (winc && wfull)  wovf_d = 1'b1;
      if (rinc && rempty) rudf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wovf_q   <= 1'b0;
      rudf_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wovf_q   <= wovf_d;
      rudf_q   <= rudf_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Write enable is qualified by rst_n so nothing lands in the array on an edge seen during reset.
  sync_fifo_ram #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (push & rst_n),
    .waddr_i(wptr_q[ADDRSIZE-1:0]),
    .wdata_i(wdata),
    .re_i   (pop),
    .raddr_i(rptr_q[ADDRSIZE-1:0]),
    .rdata_o(rdata)
  );

  a_count_tracks_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    count_q == (wptr_q - rptr_q));

  assign wovf   = wovf_q;
  assign rudf   = rudf_q;
  assign rvalid = rvalid_q;
  assign count  = count_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: vector table for fill/drain/error flags,
// hand-written corner sequences, and a queue scoreboard for wrap and streaming.
module tb_sync_fifo_ctrl;

  localparam int DS    = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk;
  logic          rst_n, clr, winc, rinc;
  logic [DS-1:0] wdata;
  logic          wfull, walmost_full, wovf, rvalid, rempty, ralmost_empty, rudf;
  logic [DS-1:0] rdata;
  logic [AS:0]   count;

  int errors = 0;
  int checks = 0;

  sync_fifo_ctrl #(.DATASIZE(DS), .ADDRSIZE(AS), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full), .wovf(wovf),
    .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rudf(rudf), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       winc, rinc, clr;
    logic [7:0] wdata;
    logic [4:0] cnt;
    logic       full, afull, ovf, empty, aempty, udf, rv, chk_rd;
    logic [7:0] rd;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [7:0] d,
                              input int cnt, input logic ovf, input logic udf, input logic rv,
                              input logic chk_rd, input logic [7:0] rd);
    vec_t v;
    v.winc = w; v.rinc = r; v.clr = c; v.wdata = d;
    v.cnt = 5'(cnt);
    v.full = (cnt == DEPTH); v.afull = (cnt >= AF);
    v.empty = (cnt == 0);    v.aempty = (cnt <= AE);
    v.ovf = ovf; v.udf = udf; v.rv = rv; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    winc = w; rinc = r; clr = c; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".count"}, count, v.cnt);
    chk({tag, ".wfull"}, wfull, v.full);
    chk({tag, ".walmost_full"}, walmost_full, v.afull);
    chk({tag, ".rempty"}, rempty, v.empty);
    chk({tag, ".ralmost_empty"}, ralmost_empty, v.aempty);
    chk({tag, ".wovf"}, wovf, v.ovf);
    chk({tag, ".rudf"}, rudf, v.udf);
    chk({tag, ".rvalid"}, rvalid, v.rv);
    if (v.chk_rd) chk({tag, ".rdata"}, rdata, v.rd);
  endtask

  task automatic mstep(input logic w, input logic r, input logic [7:0] d);
    bit         pu, po;
    logic [7:0] exp_rd;
    exp_rd = '0;
    pu = w && (sb.size() < DEPTH);
    po = r && (sb.size() > 0);
    if (po) exp_rd = sb.pop_front();
    if (pu) sb.push_back(d);
    step(w, r, 1'b0, d);
    chk("sb.count", count, sb.size());
    chk("sb.rvalid", rvalid, po);
    if (po) chk("sb.rdata", rdata, exp_rd);
    chk("sb.rempty", rempty, sb.size() == 0);
    chk("sb.wfull", wfull, sb.size() == DEPTH);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;

    // Fill, overflow, drain, underflow, flush.
    for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(1, 0, 0, 8'(i), i + 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h99, 16, 1, 0, 0, 0, 0));
    for (int k = 0; k < DEPTH; k++) vecs.push_back(mk(0, 1, 0, 0, 15 - k, 1, 0, 1, 1, 8'(k)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h0F));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 8'h0F));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h0F));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].winc, vecs[i].rinc, vecs[i].clr, vecs[i].wdata);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Full FIFO with simultaneous push/pop: pop taken, 0xAA dropped.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h10 + i));
    chk("full.count", count, 16);
    step(1, 1, 0, 8'hAA);
    chk("fullrw.count", count, 15);
    chk("fullrw.rvalid", rvalid, 1);
    chk("fullrw.rdata", rdata, 8'h10);
    chk("fullrw.wovf", wovf, 1);
    chk("fullrw.wfull", wfull, 0);
    for (int k = 0; k < DEPTH - 1; k++) begin
      step(0, 1, 0, 0);
      chk("fulldrain.rdata", rdata, 8'(8'h11 + k));
    end
    chk("fulldrain.count", count, 0);
    chk("fulldrain.rempty", rempty, 1);

    // Empty FIFO with simultaneous push/pop: push taken, no fall-through.
    step(1, 1, 0, 8'h55);
    chk("emptyrw.count", count, 1);
    chk("emptyrw.rudf", rudf, 1);
    chk("emptyrw.rvalid", rvalid, 0);
    step(0, 1, 0, 0);
    chk("emptyrw.pop_rdata", rdata, 8'h55);
    chk("emptyrw.pop_rvalid", rvalid, 1);
    step(0, 0, 1, 0);

    // Flush at count 5 with wovf set and requests present.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h20 + i));
    step(1, 0, 0, 8'h77);
    for (int k = 0; k < 11; k++) step(0, 1, 0, 0);
    chk("preclr.count", count, 5);
    chk("preclr.wovf", wovf, 1);
    step(1, 1, 1, 8'hEE);
    chk("clr.count", count, 0);
    chk("clr.rempty", rempty, 1);
    chk("clr.wovf", wovf, 0);
    chk("clr.rudf", rudf, 0);
    chk("clr.rvalid", rvalid, 0);
    chk("clr.rdata_hold", rdata, 8'h2A);
    step(0, 0, 0, 0);
    chk("postclr.count", count, 0);
    step(1, 0, 0, 8'h3C);
    step(0, 1, 0, 0);
    chk("postclr.rdata", rdata, 8'h3C);
    chk("postclr.rempty", rempty, 1);

    // Pointer wrap with blocks of 10, then an irregular interleave.
    sb.delete();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 10; i++) mstep(1, 0, 8'(rep * 16 + i + 8'h40));
      for (int i = 0; i < 10; i++) mstep(0, 1, 0);
    end
    for (int i = 0; i < 40; i++) mstep((i % 3) != 0, (i % 2) == 1, 8'(8'hA0 + i));
    while (sb.size() > 0) mstep(0, 1, 0);

    // Streaming at count 8.
    for (int i = 0; i < 8; i++) mstep(1, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 20; i++) mstep(1, 1, 8'(8'hD0 + i));
    chk("stream.count", count, 8);

    // Asynchronous reset mid-stream.
    mstep(0, 1, 0);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_vec("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    @(negedge clk);
    winc = 1'b1; wdata = 8'h66;
    @(posedge clk);
    #1;
    chk("rst_held.count", count, 0);
    @(negedge clk);
    winc = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    mstep(1, 0, 8'h5A);
    mstep(0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
